// File: rtl/fir_cfg_pkg.sv
// -----------------------------------------------------------------------------
// fir_cfg_pkg
// Shared configuration for the reconfigurable FIR coefficient path: coefficient
// count limits, RAM bank geometry, bus widths and the loader state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package fir_cfg_pkg;

    localparam int MAX_COEFF  = 33;  // largest legal coefficient count
    localparam int BANK_DEPTH = 10;  // coefficients per RAM bank
    localparam int COEFF_W    = 16;  // signed coefficient width
    localparam int ADDR_W     = 4;   // RAM address width
    localparam int CNT_W      = 6;   // coefficient count / index width

    typedef enum logic [2:0] {
        IDLE,
        FLAG,
        WAIT_DATA,
        WRITE,
        GAP,
        DONE
    } loaderStateT;

    // A count is legal when it is in 1..maxCoeff.
    function automatic logic isLegalCount(input logic [CNT_W-1:0] n, input int maxCoeff);
        return (n != '0) && (int'(n) <= maxCoeff);
    endfunction

endpackage

// File: rtl/fir_coeff_addr_gen.sv
// -----------------------------------------------------------------------------
// fir_coeff_addr_gen
// Holds the running coefficient index k (1-based) and a RAM address counter
// that wraps 1..BANK_DEPTH, so the filter sees the same address range for each
// bank while its controller picks the bank from write order.
//
// Ports:
//   iClk    clock
//   iRsn    asynchronous active-low reset
//   iLoad   restart the sequence: k=1, address=1 (wins over iInc)
//   iInc    advance to the next coefficient
//   iCount  latched coefficient count to compare k against
//   oAddr   RAM address for the current k
//   oLast   high when k equals iCount
// -----------------------------------------------------------------------------
module fir_coeff_addr_gen #(
    parameter int BANK_DEPTH = fir_cfg_pkg::BANK_DEPTH
) (
    input  logic                           iClk,
    input  logic                           iRsn,
    input  logic                           iLoad,
    input  logic                           iInc,
    input  logic [fir_cfg_pkg::CNT_W-1:0]  iCount,
    output logic [fir_cfg_pkg::ADDR_W-1:0] oAddr,
    output logic                           oLast
);
    import fir_cfg_pkg::*;

    logic [CNT_W-1:0] idx;

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            idx   <= CNT_W'(1);
            oAddr <= ADDR_W'(1);
        end else if (iLoad) begin
            idx   <= CNT_W'(1);
            oAddr <= ADDR_W'(1);
        end else if (iInc) begin
            idx   <= idx + CNT_W'(1);
            oAddr <= (oAddr == ADDR_W'(BANK_DEPTH)) ? ADDR_W'(1) : oAddr + ADDR_W'(1);
        end
    end

    assign oLast = (idx == iCount);

endmodule

// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
// Host-side coefficient writer for the transposed FIR filter. Accepts a
// coefficient stream and turns each accepted word into one RAM write on the
// filter's coefficient-update port, framed by the update flag.
//
// Stream handshake: a word transfers on a rising edge where iCoeffValid and
// oCoeffReady are both high. oCoeffReady is only high in WAIT_DATA; the host
// may raise iCoeffValid at any time and must hold iCoeffData stable while
// iCoeffValid is high and the word has not yet transferred.
//
// Ports:
//   iClk_12M, iRsn       clock, asynchronous active-low reset
//   iStart, iNumOfCoeff  begin an update of iNumOfCoeff coefficients (IDLE only)
//   iAbort               terminate an update in progress
//   iCoeffValid/Data     coefficient stream in; oCoeffReady stream ready
//   oCoeffiUpdateFlag    high for the whole update window
//   oCsnRam, oWrnRam     RAM chip select / write enable, active low
//   oAddrRam, oWrDtRam   RAM address (1..BANK_DEPTH) and write data
//   oNumOfCoeff          latched count forwarded to the filter
//   oBusy, oDone, oErr   status: not idle, completion pulse, error/abort pulse
//   oFsmState            current FSM state, for observation
// All outputs except oFsmState are registered from the next state, so each
// output already reflects the state the FSM is in during that cycle.
// -----------------------------------------------------------------------------
module fir_coeff_loader #(
    parameter int MAX_COEFF  = fir_cfg_pkg::MAX_COEFF,
    parameter int BANK_DEPTH = fir_cfg_pkg::BANK_DEPTH
) (
    input  logic                                   iClk_12M,
    input  logic                                   iRsn,
    input  logic                                   iStart,
    input  logic [fir_cfg_pkg::CNT_W-1:0]          iNumOfCoeff,
    input  logic                                   iAbort,
    input  logic                                   iCoeffValid,
    input  logic signed [fir_cfg_pkg::COEFF_W-1:0] iCoeffData,
    output logic                                   oCoeffReady,
    output logic                                   oCoeffiUpdateFlag,
    output logic                                   oCsnRam,
    output logic                                   oWrnRam,
    output logic [fir_cfg_pkg::ADDR_W-1:0]         oAddrRam,
    output logic signed [fir_cfg_pkg::COEFF_W-1:0] oWrDtRam,
    output logic [fir_cfg_pkg::CNT_W-1:0]          oNumOfCoeff,
    output logic                                   oBusy,
    output logic                                   oDone,
    output logic                                   oErr,
    output logic [2:0]                             oFsmState
);
    import fir_cfg_pkg::*;

    loaderStateT         state;
    loaderStateT         nextState;
    logic                loadIdx;
    logic                incIdx;
    logic                errNext;
    logic [ADDR_W-1:0]   genAddr;
    logic                genLast;

    fir_coeff_addr_gen #(
        .BANK_DEPTH (BANK_DEPTH)
    ) uAddrGen (
        .iClk   (iClk_12M),
        .iRsn   (iRsn),
        .iLoad  (loadIdx),
        .iInc   (incIdx),
        .iCount (oNumOfCoeff),
        .oAddr  (genAddr),
        .oLast  (genLast)
    );

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        loadIdx   = 1'b0;
        incIdx    = 1'b0;
        errNext   = 1'b0;
        unique case (state)
            IDLE: begin
                if (iStart) begin
                    if (isLegalCount(iNumOfCoeff, MAX_COEFF)) begin
                        nextState = FLAG;
                        loadIdx   = 1'b1;
                    end else begin
                        errNext   = 1'b1;
                    end
                end
            end
            FLAG:      nextState = WAIT_DATA;
            WAIT_DATA: begin
                if (iCoeffValid && oCoeffReady) begin
                    nextState = WRITE;
                end
            end
            WRITE:     nextState = GAP;
            GAP: begin
                if (genLast) begin
                    nextState = DONE;
                end else begin
                    nextState = WAIT_DATA;
                    incIdx    = 1'b1;
                end
            end
            DONE:      nextState = IDLE;
            default:   nextState = IDLE;
        endcase

        // Abort overrides everything, including a same-cycle handshake, so the
        // word is never captured and no write follows.
        if (iAbort && (state != IDLE)) begin
            nextState = IDLE;
            incIdx    = 1'b0;
            errNext   = 1'b1;
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            oCoeffReady       <= 1'b0;
            oCoeffiUpdateFlag <= 1'b0;
            oCsnRam           <= 1'b1;
            oWrnRam           <= 1'b1;
            oAddrRam          <= '0;
            oWrDtRam          <= '0;
            oNumOfCoeff       <= '0;
            oBusy             <= 1'b0;
            oDone             <= 1'b0;
            oErr              <= 1'b0;
        end else begin
            oCoeffReady       <= (nextState == WAIT_DATA);
            oCoeffiUpdateFlag <= (nextState != IDLE);
            oCsnRam           <= (nextState != WRITE);
            oWrnRam           <= (nextState != WRITE);
            oBusy             <= (nextState != IDLE);
            oDone             <= (nextState == DONE);
            oErr              <= errNext;
            if (loadIdx) begin
                oNumOfCoeff <= iNumOfCoeff;
            end
            // Entering WRITE only happens from a WAIT_DATA handshake, so the
            // stream word and the address for the current k are valid here.
            if (nextState == WRITE) begin
                oAddrRam <= genAddr;
                oWrDtRam <= iCoeffData;
            end
        end
    end

    assign oFsmState = state;

endmodule

// File: tb/tb_fir_coeff_loader.sv
`timescale 1ns/1ps
module tb_fir_coeff_loader;
    localparam int MAX_COEFF  = 33;
    localparam int BANK_DEPTH = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rsn = 1'b0;
    always #42 clk = ~clk;

    logic               i_start;
    logic [5:0]         i_num;
    logic               i_abort;
    logic               i_valid;
    logic signed [15:0] i_data;
    logic               o_ready;
    logic               o_flag;
    logic               o_csn;
    logic               o_wrn;
    logic [3:0]         o_addr;
    logic signed [15:0] o_wrdt;
    logic [5:0]         o_num;
    logic               o_busy;
    logic               o_done;
    logic               o_err;
    logic [2:0]         o_fsm_state;

    fir_coeff_loader #(.MAX_COEFF(MAX_COEFF), .BANK_DEPTH(BANK_DEPTH)) dut (
        .iClk_12M          (clk),
        .iRsn              (rsn),
        .iStart            (i_start),
        .iNumOfCoeff       (i_num),
        .iAbort            (i_abort),
        .iCoeffValid       (i_valid),
        .iCoeffData        (i_data),
        .oCoeffReady       (o_ready),
        .oCoeffiUpdateFlag (o_flag),
        .oCsnRam           (o_csn),
        .oWrnRam           (o_wrn),
        .oAddrRam          (o_addr),
        .oWrDtRam          (o_wrdt),
        .oNumOfCoeff       (o_num),
        .oBusy             (o_busy),
        .oDone             (o_done),
        .oErr              (o_err),
        .oFsmState         (o_fsm_state)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- scoreboard / monitor ----------------
    logic [15:0] exp_q[$];
    logic [3:0]  got_addr[$];
    logic [15:0] got_data[$];
    int flag_cycles, done_cnt, err_cnt, strobe_cycles, busy_cycles;

    always @(negedge clk) begin
        if (!o_csn && !o_wrn) begin
            got_addr.push_back(o_addr);
            got_data.push_back(o_wrdt);
        end
        if (o_flag) flag_cycles++;
        if (o_done) done_cnt++;
        if (o_err) err_cnt++;
        if (!o_csn || !o_wrn) strobe_cycles++;
        if (o_busy) busy_cycles++;
    end

    // Reference address rule: k-th coefficient goes to ((k-1) mod depth)+1.
    function automatic logic [3:0] model_addr(input int k);
        return 4'(((k - 1) % BANK_DEPTH) + 1);
    endfunction

    task automatic clear_monitor();
        got_addr.delete();
        got_data.delete();
        exp_q.delete();
        flag_cycles = 0; done_cnt = 0; err_cnt = 0;
        strobe_cycles = 0; busy_cycles = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic start_update(input logic [5:0] n);
        @(negedge clk);
        i_start = 1'b1;
        i_num   = n;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    // Offers one word and waits for it to transfer; leaves valid high.
    task automatic push_coeff(input logic [15:0] d, output bit ok);
        int guard = 0;
        i_valid = 1'b1;
        i_data  = d;
        while (!o_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!o_ready) begin
            ok = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        @(negedge clk);
        while (o_busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_busy) begin
            failures++;
            $display("FAIL %s_timeout: busy=%0b after %0d cycles, required 0", name, o_busy, bound);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [32:0] obs;
        logic [32:0] rst_vec;
        rst_vec = {2'b11, 5'b00000, 4'h0, 16'h0000, 6'h00};
        repeat (2) @(negedge clk);
        obs = {o_csn, o_wrn, o_ready, o_flag, o_busy, o_done, o_err, o_addr, o_wrdt, o_num};
        checks++;
        if (obs !== rst_vec) begin
            failures++;
            $display("FAIL reset_values: got %h required %h", obs, rst_vec);
        end
        rsn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            obs = {o_csn, o_wrn, o_ready, o_flag, o_busy, o_done, o_err, o_addr, o_wrdt, o_num};
            checks++;
            if (obs !== rst_vec) begin
                failures++;
                $display("FAIL idle_hold cycle %0d: got %h required %h", c, obs, rst_vec);
            end
        end
    endtask

    task automatic test_basic3();
        bit ok;
        clear_monitor();
        exp_q = '{16'h0010, 16'hFFF0, 16'h7FFF};
        start_update(6'd3);
        @(negedge clk);
        checks++;
        if (o_flag !== 1'b1 || o_ready !== 1'b0) begin
            failures++;
            $display("FAIL start_latency: flag=%0b ready=%0b required flag=1 ready=0", o_flag, o_ready);
        end
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL first_ready: ready=%0b required 1", o_ready);
        end
        for (int i = 0; i < 3; i++) begin
            push_coeff(exp_q[i], ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL basic3_handshake %0d: no ready seen, required ready", i);
            end
        end
        i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_csn !== 1'b0 || o_wrn !== 1'b0) begin
            failures++;
            $display("FAIL basic3_last_write: csn=%0b wrn=%0b required 0 0", o_csn, o_wrn);
        end
        @(negedge clk);
        checks++;
        if (o_csn !== 1'b1 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL basic3_gap: csn=%0b done=%0b required 1 0", o_csn, o_done);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b1) begin
            failures++;
            $display("FAIL basic3_done: done=%0b required 1", o_done);
        end
        wait_idle("basic3", 20);
        repeat (3) @(negedge clk);
        checks++;
        if (got_addr.size() != 3) begin
            failures++;
            $display("FAIL basic3_write_count: got %0d required 3", got_addr.size());
        end
        for (int i = 0; i < 3 && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== model_addr(i + 1) || got_data[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL basic3_write %0d: addr=%0d data=%h required addr=%0d data=%h",
                         i, got_addr[i], got_data[i], model_addr(i + 1), exp_q[i]);
            end
        end
        checks++;
        if (flag_cycles != 11 || done_cnt != 1 || err_cnt != 0 || o_num !== 6'd3) begin
            failures++;
            $display("FAIL basic3_status: flag_cycles=%0d done=%0d err=%0d num=%0d required 11 1 0 3",
                     flag_cycles, done_cnt, err_cnt, o_num);
        end
    endtask

    task automatic test_long33();
        bit ok;
        clear_monitor();
        for (int i = 0; i < 33; i++) exp_q.push_back(16'($urandom));
        start_update(6'd33);
        for (int i = 0; i < 33; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                i_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
            push_coeff(exp_q[i], ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL long33_handshake %0d: no ready seen, required ready", i);
            end
        end
        i_valid = 1'b0;
        wait_idle("long33", 20);
        repeat (2) @(negedge clk);
        checks++;
        if (got_addr.size() != 33) begin
            failures++;
            $display("FAIL long33_write_count: got %0d required 33", got_addr.size());
        end
        for (int i = 0; i < 33 && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== model_addr(i + 1) || got_data[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL long33_write %0d: addr=%0d data=%h required addr=%0d data=%h",
                         i, got_addr[i], got_data[i], model_addr(i + 1), exp_q[i]);
            end
        end
        checks++;
        if (o_num !== 6'd33 || done_cnt != 1 || err_cnt != 0 || flag_cycles < 101) begin
            failures++;
            $display("FAIL long33_status: num=%0d done=%0d err=%0d flag_cycles=%0d required 33 1 0 >=101",
                     o_num, done_cnt, err_cnt, flag_cycles);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] bad[3];
        bad = '{6'd0, 6'd34, 6'd63};
        for (int b = 0; b < 3; b++) begin
            clear_monitor();
            start_update(bad[b]);
            repeat (6) @(negedge clk);
            checks++;
            if (err_cnt != 1 || flag_cycles != 0 || strobe_cycles != 0 || busy_cycles != 0 || o_num !== 6'd33) begin
                failures++;
                $display("FAIL illegal_count n=%0d: err=%0d flag=%0d strobe=%0d busy=%0d num=%0d required 1 0 0 0 33",
                         bad[b], err_cnt, flag_cycles, strobe_cycles, busy_cycles, o_num);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        int guard = 0;
        clear_monitor();
        for (int i = 0; i < 20; i++) exp_q.push_back(16'($urandom));
        start_update(6'd20);
        for (int i = 0; i < 7; i++) begin
            push_coeff(exp_q[i], ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL abort_handshake %0d: no ready seen, required ready", i);
            end
        end
        i_valid = 1'b0;
        while (!o_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        // Abort together with a valid word: the word must be dropped.
        i_valid = 1'b1;
        i_data  = exp_q[7];
        i_abort = 1'b1;
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_flag !== 1'b0 || o_err !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_response: flag=%0b err=%0b busy=%0b ready=%0b required 0 1 0 0",
                     o_flag, o_err, o_busy, o_ready);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (got_addr.size() != 7 || strobe_cycles != 7) begin
            failures++;
            $display("FAIL abort_write_count: got %0d writes %0d strobe cycles required 7 7",
                     got_addr.size(), strobe_cycles);
        end
        for (int i = 0; i < 7 && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== model_addr(i + 1) || got_data[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL abort_write %0d: addr=%0d data=%h required addr=%0d data=%h",
                         i, got_addr[i], got_data[i], model_addr(i + 1), exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != 0 || err_cnt != 1) begin
            failures++;
            $display("FAIL abort_status: done=%0d err=%0d required 0 1", done_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_monitor();
        for (int i = 0; i < 10; i++) exp_q.push_back(16'($urandom));
        start_update(6'd10);
        for (int i = 0; i < 5; i++) push_coeff(exp_q[i], ok);
        checks++;
        if (o_csn !== 1'b0 || o_wrn !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_write_active: csn=%0b wrn=%0b required 0 0", o_csn, o_wrn);
        end
        #5 rsn = 1'b0;
        #1;
        checks++;
        if (o_csn !== 1'b1 || o_wrn !== 1'b1 || o_flag !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: csn=%0b wrn=%0b flag=%0b busy=%0b ready=%0b required 1 1 0 0 0",
                     o_csn, o_wrn, o_flag, o_busy, o_ready);
        end
        i_valid = 1'b0;
        @(negedge clk);
        rsn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 0 || o_num !== 6'd0) begin
            failures++;
            $display("FAIL reset_mid_status: done=%0d num=%0d required 0 0", done_cnt, o_num);
        end

        clear_monitor();
        exp_q.push_back(16'($urandom));
        exp_q.push_back(16'($urandom));
        start_update(6'd2);
        for (int i = 0; i < 2; i++) begin
            push_coeff(exp_q[i], ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL after_reset_handshake %0d: no ready seen, required ready", i);
            end
        end
        i_valid = 1'b0;
        wait_idle("after_reset", 20);
        repeat (2) @(negedge clk);
        checks++;
        if (got_addr.size() != 2 || done_cnt != 1 || flag_cycles != 8) begin
            failures++;
            $display("FAIL after_reset_status: writes=%0d done=%0d flag_cycles=%0d required 2 1 8",
                     got_addr.size(), done_cnt, flag_cycles);
        end
        for (int i = 0; i < 2 && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== model_addr(i + 1) || got_data[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL after_reset_write %0d: addr=%0d data=%h required addr=%0d data=%h",
                         i, got_addr[i], got_data[i], model_addr(i + 1), exp_q[i]);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        i_start = 1'b0;
        i_num   = '0;
        i_abort = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        clear_monitor();
        test_reset();
        test_basic3();
        test_long33();
        test_illegal();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
